piso_shift_controller: RTL and testbench

//  Sequences a parallel-in/serial-out shift datapath: accepts a WIDTH-bit word over a

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_shreg.sv | 48 ++++
 rtl/piso_shift_controller.sv | 160 ++++++++++++++++
 tb/tb_piso_shift_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the PISO shift controller slice.
//   - State encodings and the controller state enum (IDLE / SHIFT / PARITY).
// PARITY is only reachable when the design is built with PISO_PARITY_EN.
// -----------------------------------------------------------------------------
package piso_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_SHIFT  = 2'd1;
    localparam logic [1:0] ENC_PARITY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_SHIFT  = ENC_SHIFT,
        ST_PARITY = ENC_PARITY
    } piso_state_e;

endpackage : piso_pkg

// File: rtl/piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg
// WIDTH-bit parallel-load / right-shift register. Load has priority over
// shift; shifting moves bits toward bit 0 with zero fill at the MSB.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (register clears to 0)
//   load_en_i  in   capture data_i this cycle
//   shift_en_i in   shift right by one this cycle (ignored while loading)
//   data_i     in   parallel word
//   lsb_o      out  current bit 0 (the next bit to leave the register)
// -----------------------------------------------------------------------------
module piso_shreg
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             lsb_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_en_i) begin
            shreg_d = data_i;
        end else if (shift_en_i) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign lsb_o = shreg_q[0];

endmodule : piso_shreg

// File: rtl/piso_shift_controller.sv
// -----------------------------------------------------------------------------
// piso_shift_controller
// Accepts a WIDTH-bit word over load_valid/load_ready and sends it out LSB
// first, one bit per shift_en tick, with frame_start/frame_end markers.
// Optional build macro: PISO_PARITY_EN appends one even-parity bit per frame.
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   load_valid    producer offers load_data
//   load_data     parallel word, bit 0 sent first
//   load_ready    controller can take a word this cycle
//   shift_en      bit-rate tick; serial output only advances when high
//   ser_out       serial bit (0 while ser_valid is low)
//   ser_valid     ser_out is a live frame bit
//   frame_start   ser_out is bit 0 of a frame
//   frame_end     ser_out is the last bit of a frame
//   busy          controller is not IDLE
//   dbg_state     current FSM state, for checkers
//
// Handshake: a word is consumed on a cycle where load_valid && load_ready,
// except in the final-bit cycle of a frame, where load_ready is advertised
// regardless of shift_en but the word is only consumed when shift_en is also
// high (the new frame must start exactly when the old one's last bit leaves).
// load_ready depends only on state/count, never on load_valid.
// -----------------------------------------------------------------------------
module piso_shift_controller
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    piso_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic             shreg_lsb;
    logic             last_bit;
    logic             ready_slot;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    assign last_bit = (state_q == ST_SHIFT) && (count_q == LAST_CNT);

    // The cycle in which a follow-on word may be taken is the final bit of
    // the frame: the parity bit when enabled, otherwise the last data bit.
`ifdef PISO_PARITY_EN
    assign ready_slot = (state_q == ST_PARITY);
`else
    assign ready_slot = last_bit;
`endif

    assign load_ready = (state_q == ST_IDLE) || ready_slot;
    assign accept     = load_valid && ((state_q == ST_IDLE) || (ready_slot && shift_en));

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en_i  (accept),
        .shift_en_i (shift_en && (state_q == ST_SHIFT)),
        .data_i     (load_data),
        .lsb_o      (shreg_lsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_SHIFT;
                        count_q  <= '0;
`ifdef PISO_PARITY_EN
                        parity_q <= ^load_data;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (shift_en) begin
                        if (count_q == LAST_CNT) begin
`ifdef PISO_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            count_q <= '0;
                            // Back-to-back: the reloaded register keeps us in SHIFT.
                            if (!accept) begin
                                state_q <= ST_IDLE;
                            end
`endif
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    if (shift_en) begin
                        count_q <= '0;
                        if (accept) begin
                            state_q  <= ST_SHIFT;
                            parity_q <= ^load_data;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    // Output decode is a pure function of the registered state, so all
    // outputs settle from flops and clear immediately on reset.
    always_comb begin
        ser_out = 1'b0;
        case (state_q)
            ST_SHIFT:  ser_out = shreg_lsb;
`ifdef PISO_PARITY_EN
            ST_PARITY: ser_out = parity_q;
`endif
            default:   ser_out = 1'b0;
        endcase
    end

    assign ser_valid   = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign frame_start = (state_q == ST_SHIFT) && (count_q == '0);
`ifdef PISO_PARITY_EN
    assign frame_end   = (state_q == ST_PARITY);
`else
    assign frame_end   = last_bit;
`endif
    assign dbg_state   = state_q;

endmodule : piso_shift_controller

// File: tb/tb_piso_shift_controller.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_controller
// Directed and random stimulus against a frame-level model: each accepted
// word becomes a queue of expected serial bits (data LSB first, plus the
// even-parity bit when PISO_PARITY_EN is defined). The model state is just
// "bits left in the current frame" and "position within the frame".
// -----------------------------------------------------------------------------
module tb_piso_shift_controller;

    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst_n;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;
    logic [1:0]       dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    piso_shift_controller #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .shift_en    (shift_en),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    logic exp_q[$];   // expected serial bits still to be sent
    logic cap_q[$];   // bits observed leaving the DUT (ser_valid && shift_en)
    int   pos;        // index of the current bit within its frame
    logic acc_last;   // model says the last step consumed a word
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^w);
`endif
        pos = 0;
    endtask

    task automatic check_outputs();
        int n;
        n = exp_q.size();
        chk("ser_valid",   16'(ser_valid),   16'(n > 0));
        chk("busy",        16'(busy),        16'(n > 0));
        chk("ser_out",     16'(ser_out),     16'((n > 0) ? exp_q[0] : 1'b0));
        chk("frame_start", 16'(frame_start), 16'((n > 0) && (pos == 0)));
        chk("frame_end",   16'(frame_end),   16'(n == 1));
        chk("load_ready",  16'(load_ready),  16'(n <= 1));
    endtask

    // ---------------- driver ----------------
    // Drive inputs just after a rising edge, check at the falling edge,
    // then advance the model across the next rising edge.
    task automatic step(input logic lv, input logic [WIDTH-1:0] ld, input logic se);
        int n;
        load_valid = lv;
        load_data  = ld;
        shift_en   = se;
        @(negedge clk);
        check_outputs();
        if (ser_valid && se) cap_q.push_back(ser_out);
        n = exp_q.size();
        acc_last = lv && ((n == 0) || ((n == 1) && se));
        if (se && (n > 0)) begin
            void'(exp_q.pop_front());
            pos++;
        end
        if (acc_last) push_word(ld);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cap(input string tag, input logic [15:0] expv, input int len);
        logic [15:0] got;
        got = '0;
        chk({tag, "_len"}, 16'(cap_q.size()), 16'(len));
        for (int i = 0; i < cap_q.size() && i < 16; i++) got[i] = cap_q[i];
        chk(tag, got, expv);
        cap_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int k;
        logic [WIDTH-1:0] word;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b0;
        pos        = 0;
        acc_last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();                  // reset state
        rst_n = 1'b1;

        // Single word 1011, continuous ticks
        cap_q.delete();
        step(1'b1, 4'hB, 1'b1);
        repeat (FLEN) step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b1);           // busy must have fallen
`ifdef PISO_PARITY_EN
        check_cap("t2_bits", 16'h1B, 5);
`else
        check_cap("t2_bits", 16'h0B, 4);
`endif

        // Back-to-back A then 5 with load_valid held
        step(1'b1, 4'hA, 1'b1);
        k = 0;
        do begin
            step(1'b1, 4'h5, 1'b1);
            k++;
        end while (!acc_last && k < 20);
        chk("t3_accept", 16'(acc_last), 16'h1);
        repeat (FLEN) step(1'b0, 4'h0, 1'b1);
`ifdef PISO_PARITY_EN
        check_cap("t3_bits", 16'h0AA, 10);
`else
        check_cap("t3_bits", 16'h05A, 8);
`endif

        // Stall pattern 1-0-0-1
        step(1'b1, 4'h6, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        repeat (FLEN) step(1'b0, 4'h0, 1'b1);
        check_cap("t4_bits", 16'h0006, FLEN);

        // Word offered mid-frame is only taken in the final-bit cycle
        step(1'b1, 4'h3, 1'b1);
        k = 0;
        do begin
            step(1'b1, 4'hC, 1'b1);
            k++;
        end while (!acc_last && k < 20);
        chk("t5_accept_cycle", 16'(k), 16'(FLEN));
        repeat (FLEN + 1) step(1'b0, 4'h0, 1'b1);
        cap_q.delete();

`ifdef PISO_PARITY_EN
        // Parity frame 0111 -> 1,1,1,0 then parity 1
        step(1'b1, 4'h7, 1'b1);
        repeat (FLEN) step(1'b0, 4'h0, 1'b1);
        check_cap("t6_bits", 16'h0017, 5);
`endif

        // Reset mid-frame aborts it
        step(1'b1, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        pos = 0;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        cap_q.delete();
        repeat (6) step(1'b0, 4'h0, 1'b1);
        chk("t1_no_bits", 16'(cap_q.size()), 16'h0);

        // Random traffic: producer holds each word until it is consumed
        word = 4'($urandom);
        repeat (400) begin
            step(($urandom_range(0, 3) != 0), word, ($urandom_range(0, 9) < 7));
            if (acc_last) word = 4'($urandom);
        end
        repeat (2 * FLEN + 2) step(1'b0, 4'h0, 1'b1);
        chk("drain_busy", 16'(busy), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_piso_shift_controller
